// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file with prioritised write bypass, debug read and bulk-clear sequencer
module reg_file_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  input  logic                     clr_req,
  output logic                     clr_busy
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_clr_idx;
  logic              r_busy;
  logic              w_idle, w_en0, w_en1, w_wr0, w_wr1;
  assign w_idle   = (r_state == IDLE);
  assign w_en0    = w_idle && we0;
  assign w_en1    = w_idle && we1;
  assign w_wr1    = w_en1 && !(ZERO_REG != 0 && waddr1 == '0);
  assign w_wr0    = w_en0 && !(ZERO_REG != 0 && waddr0 == '0) && !(we1 && waddr1 == waddr0);
  assign clr_busy = r_busy;
  assign dbg_data = (ZERO_REG != 0 && dbg_addr == '0) ? '0 : r_mem[dbg_addr];
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = clr_req ? CLEAR : IDLE;
    else
      w_next = (r_clr_idx == ADDR_W'(DEPTH-1)) ? IDLE : CLEAR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_clr_idx <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clr_idx <= w_idle ? '0 : r_clr_idx + 1'b1;
      r_busy    <= (w_next == CLEAR);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (!w_idle) begin
      r_mem[r_clr_idx] <= '0;
    end else begin
      if (w_wr0) r_mem[waddr0] <= wdata0;
      if (w_wr1) r_mem[waddr1] <= wdata1;
    end
  end
  // Bypass honours the same port-1-first priority as the commit, and is off during CLEAR
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    assign w_a = raddr[i*ADDR_W +: ADDR_W];
    assign rdata[i*DATA_W +: DATA_W] =
      (ZERO_REG != 0 && w_a == '0) ? '0 :
      (w_en1 && waddr1 == w_a)     ? wdata1 :
      (w_en0 && waddr0 == w_a)     ? wdata0 : r_mem[w_a];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp, four read ports
module tb_reg_file_mp;
  localparam int DW = 8, AW = 5, NR = 4;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] waddr0 = '0, waddr1 = '0, dbg_addr = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, dbg_data;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic          clr_busy;
  int n_tests = 0, n_fail = 0;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  task automatic chk_rd(input string name, input int p, input logic [DW-1:0] exp);
    n_tests++;
    if (rd(p) !== exp) begin
      n_fail++;
      $display("FAIL %s port%0d: got %h expected %h", name, p, rd(p), exp);
    end
  endtask

  task automatic chk_dbg(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    dbg_addr = a;
    #1;
    n_tests++;
    if (dbg_data !== exp) begin
      n_fail++;
      $display("FAIL %s dbg[%0d]: got %h expected %h", name, a, dbg_data, exp);
    end
  endtask

  task automatic test_reset();
    for (int p = 0; p < NR; p++) set_rd(p, 5'd5);
    dbg_addr = 5'd5;
    tick();
    for (int p = 0; p < NR; p++) chk_rd("reset_rd", p, 8'h00);
    chk_dbg("reset_dbg", 5'd5, 8'h00);
    n_tests++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", clr_busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 8'hA5; set_rd(0, 5'd3);
    #1;
    chk_rd("bypass_same_cycle", 0, 8'hA5);
    chk_dbg("bypass_dbg_not_bypassed", 5'd3, 8'h00);
    tick();
    we0 = 1'b0;
    chk_dbg("bypass_stored", 5'd3, 8'hA5);
    chk_rd("bypass_stored_rd", 0, 8'hA5);
  endtask

  task automatic test_priority();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 8'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 8'h22;
    set_rd(1, 5'd7);
    #1;
    chk_rd("prio_bypass", 1, 8'h22);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    chk_dbg("prio_stored", 5'd7, 8'h22);
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 8'hFF;
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 8'hFF;
    for (int p = 0; p < NR; p++) set_rd(p, 5'd0);
    #1;
    for (int p = 0; p < NR; p++) chk_rd("zero_bypass", p, 8'h00);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    chk_dbg("zero_dbg", 5'd0, 8'h00);
    chk_rd("zero_stored", 2, 8'h00);
  endtask

  task automatic test_clear();
    int cnt;
    for (int a = 1; a < 32; a++) begin
      we0 = 1'b1; waddr0 = AW'(a); wdata0 = DW'(a);
      tick();
    end
    we0 = 1'b0;
    chk_dbg("fill_9", 5'd9, 8'h09);
    chk_dbg("fill_31", 5'd31, 8'h1F);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    set_rd(0, 5'd9);
    while (clr_busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 5) begin
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 8'h99;
        #1;
        chk_rd("clear_no_bypass", 0, 8'h09);
      end
      tick();
      we1 = 1'b0;
    end
    n_tests++;
    if (cnt != 32) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d cycles expected 32", cnt);
    end
    for (int a = 0; a < 32; a++) chk_dbg("clear_entry", AW'(a), 8'h00);
    chk_rd("clear_lost_write", 0, 8'h00);
  endtask

  task automatic test_reset_clear();
    we0 = 1'b1; waddr0 = 5'd20; wdata0 = 8'h5A;
    tick();
    we0 = 1'b0;
    chk_dbg("pre_abort", 5'd20, 8'h5A);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    n_tests++;
    if (clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: got %b expected 1", clr_busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy_async: got %b expected 0", clr_busy);
    end
    for (int a = 0; a < 32; a++) chk_dbg("abort_entry", AW'(a), 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 8'h3C;
    tick();
    we0 = 1'b0;
    set_rd(3, 5'd4);
    chk_dbg("after_abort_dbg", 5'd4, 8'h3C);
    chk_rd("after_abort_rd", 3, 8'h3C);
    n_tests++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_abort_busy: got %b expected 0", clr_busy);
    end
  endtask

  task automatic test_four_ports();
    we1 = 1'b1; waddr1 = 5'd10; wdata1 = 8'hAA;
    tick();
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 8'hC3;
    we1 = 1'b1; waddr1 = 5'd13; wdata1 = 8'hD4;
    set_rd(0, 5'd4); set_rd(1, 5'd10); set_rd(2, 5'd12); set_rd(3, 5'd13);
    #1;
    chk_rd("quad_stored4", 0, 8'h3C);
    chk_rd("quad_stored10", 1, 8'hAA);
    chk_rd("quad_byp0", 2, 8'hC3);
    chk_rd("quad_byp1", 3, 8'hD4);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    chk_dbg("quad_commit12", 5'd12, 8'hC3);
    chk_dbg("quad_commit13", 5'd13, 8'hD4);
    chk_rd("quad_after12", 2, 8'hC3);
    chk_rd("quad_after13", 3, 8'hD4);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_priority();
    test_clear();
    test_reset_clear();
    test_four_ports();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
